// File: rtl/mips_host_driver_if.sv
// mips_host_driver_if
// Single-instruction bus between the host driver and the MIPS core.
//   in_valid          one-cycle issue pulse (driver -> core)
//   instruction       32-bit instruction word (driver -> core)
//   output_reg        four packed 5-bit result register addresses (driver -> core)
//   out_valid         one-cycle response pulse (core -> driver)
//   out_1..out_4      16-bit results (core -> driver)
//   instruction_fail  core rejected or failed the instruction (core -> driver)
interface mips_host_driver_if;
  logic        in_valid;
  logic [31:0] instruction;
  logic [19:0] output_reg;
  logic        out_valid;
  logic [15:0] out_1;
  logic [15:0] out_2;
  logic [15:0] out_3;
  logic [15:0] out_4;
  logic        instruction_fail;

  modport master (
    output in_valid,
    output instruction,
    output output_reg,
    input  out_valid,
    input  out_1,
    input  out_2,
    input  out_3,
    input  out_4,
    input  instruction_fail
  );

  modport slave (
    input  in_valid,
    input  instruction,
    input  output_reg,
    output out_valid,
    output out_1,
    output out_2,
    output out_3,
    output out_4,
    output instruction_fail
  );
endinterface

// File: rtl/mips_host_driver.sv
// mips_host_driver
// Host-side initiator for the MIPS core single-instruction interface.
// Commands are queued in a small FIFO and issued one at a time; the core's
// one-cycle response is held on a valid/ready result port. A watchdog turns
// a missing response into a timeout result.
//
// State table
//   state | meaning
//   IDLE  | waiting for a queued command (result port empty)
//   ISSUE | in_valid pulse, popped command on the bus
//   WAIT  | response outstanding, watchdog running
//   RESP  | result held on res_* until res_ready
//
// Ports
//   clk, rst_n         clock; rst_n is a synchronous ACTIVE-HIGH reset
//   cmd_valid/ready    producer handshake, cmd_ready = FIFO not full
//   cmd_instruction    instruction to queue
//   cmd_output_reg     output register addresses to queue
//   core               core bus (master side)
//   res_valid/ready    consumer handshake for the captured result
//   res_data           {out_4, out_3, out_2, out_1}
//   res_fail           captured instruction_fail
//   res_timeout        result was produced by the watchdog
//   busy               FSM active or commands queued
//   issued_cnt         instructions issued (wrapping)
//   fail_cnt           fails plus timeouts (saturating)
module mips_host_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instruction,
  input  logic [19:0] cmd_output_reg,
  mips_host_driver_if.master core,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_fail,
  output logic        res_timeout,
  output logic        busy,
  output logic [7:0]  issued_cnt,
  output logic [7:0]  fail_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem_instr [DEPTH];
  logic [19:0] mem_oreg  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] issue_instr;
  logic [19:0] issue_oreg;
  logic [WW-1:0] wd;

  logic push, pop;
  logic capture_rsp, capture_to;
  logic wd_expire;

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  // In WAIT cycle k after the issue pulse wd holds k-1, so expiring at
  // TIMEOUT-2 makes the timeout result visible exactly TIMEOUT cycles after
  // in_valid.
  assign wd_expire = (wd == WW'(TIMEOUT - 2));

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    capture_rsp = 1'b0;
    capture_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((count != '0) && !res_valid) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A response arriving on the expiry cycle takes priority.
        if (core.out_valid) begin
          capture_rsp = 1'b1;
          state_nxt   = ST_RESP;
        end else if (wd_expire) begin
          capture_to  = 1'b1;
          state_nxt   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign res_valid        = (state == ST_RESP);
  assign core.in_valid    = (state == ST_ISSUE);
  assign core.instruction = (state == ST_ISSUE) ? issue_instr : 32'd0;
  assign core.output_reg  = (state == ST_ISSUE) ? issue_oreg  : 20'd0;
  assign busy             = (state != ST_IDLE) || (count != '0);

  // FIFO storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= cmd_instruction;
      mem_oreg[wr_ptr]  <= cmd_output_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      issue_instr <= '0;
      issue_oreg  <= '0;
      wd          <= '0;
      res_data    <= '0;
      res_fail    <= 1'b0;
      res_timeout <= 1'b0;
      issued_cnt  <= '0;
      fail_cnt    <= '0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        issue_instr <= mem_instr[rd_ptr];
        issue_oreg  <= mem_oreg[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (state == ST_ISSUE) begin
        wd         <= '0;
        issued_cnt <= issued_cnt + 8'd1;
      end else if (state == ST_WAIT) begin
        wd <= wd + WW'(1);
      end

      if (capture_rsp) begin
        res_data    <= {core.out_4, core.out_3, core.out_2, core.out_1};
        res_fail    <= core.instruction_fail;
        res_timeout <= 1'b0;
        if (core.instruction_fail && (fail_cnt != 8'hFF)) fail_cnt <= fail_cnt + 8'd1;
      end else if (capture_to) begin
        res_data    <= '0;
        res_fail    <= 1'b0;
        res_timeout <= 1'b1;
        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_host_driver.sv
module tb_mips_host_driver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_instruction;
  logic [19:0] cmd_output_reg;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_fail;
  logic        res_timeout;
  logic        busy;
  logic [7:0]  issued_cnt;
  logic [7:0]  fail_cnt;

  mips_host_driver_if core_if();

  mips_host_driver #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_instruction (cmd_instruction),
    .cmd_output_reg  (cmd_output_reg),
    .core            (core_if.master),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_fail        (res_fail),
    .res_timeout     (res_timeout),
    .busy            (busy),
    .issued_cnt      (issued_cnt),
    .fail_cnt        (fail_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int iv_cnt = 0;
  logic [65:0] rq[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_if.in_valid) iv_cnt <= iv_cnt + 1;
    if (res_valid && res_ready) rq.push_back({res_timeout, res_fail, res_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_iv(output int c);
    int n = 0;
    while (!core_if.in_valid && n < 50) begin
      tick();
      n++;
    end
    chk("wait_in_valid", 66'(core_if.in_valid), 66'd1);
    c = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    rq.delete();
  endtask

  task automatic core_resp(input logic [15:0] o1, input logic [15:0] o2,
                           input logic [15:0] o3, input logic [15:0] o4, input logic f);
    core_if.out_valid        = 1'b1;
    core_if.out_1            = o1;
    core_if.out_2            = o2;
    core_if.out_3            = o3;
    core_if.out_4            = o4;
    core_if.instruction_fail = f;
    tick();
    core_if.out_valid        = 1'b0;
    core_if.instruction_fail = 1'b0;
  endtask

  function automatic logic [63:0] mk(input int k);
    mk = {16'h0400 + 16'(k), 16'h0300 + 16'(k), 16'h0200 + 16'(k), 16'h0100 + 16'(k)};
  endfunction

  initial begin
    int c0, iv0, n, qs;
    int ci[4];
    logic stable;

    rst_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_instruction = '0;
    cmd_output_reg = '0;
    res_ready = 1'b0;
    core_if.out_valid = 1'b0;
    core_if.out_1 = '0;
    core_if.out_2 = '0;
    core_if.out_3 = '0;
    core_if.out_4 = '0;
    core_if.instruction_fail = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;

    // reset state
    chk("rst_cmd_ready", 66'(cmd_ready), 66'd1);
    chk("rst_in_valid", 66'(core_if.in_valid), 66'd0);
    chk("rst_instruction", 66'(core_if.instruction), 66'd0);
    chk("rst_res_valid", 66'(res_valid), 66'd0);
    chk("rst_res_data", 66'(res_data), 66'd0);
    chk("rst_busy", 66'(busy), 66'd0);
    chk("rst_issued", 66'(issued_cnt), 66'd0);
    chk("rst_fail_cnt", 66'(fail_cnt), 66'd0);

    // single ADDI
    iv0 = iv_cnt;
    cmd_valid = 1'b1;
    cmd_instruction = 32'h2232_0005;
    cmd_output_reg = 20'h94A52;
    tick();
    cmd_valid = 1'b0;
    chk("addi_busy", 66'(busy), 66'd1);
    wait_iv(c0);
    chk("addi_instr", 66'(core_if.instruction), 66'h2232_0005);
    chk("addi_oreg", 66'(core_if.output_reg), 66'h94A52);
    tick();
    chk("addi_iv_one_cycle", 66'(core_if.in_valid), 66'd0);
    chk("addi_instr_idle", 66'(core_if.instruction), 66'd0);
    tick();
    core_resp(16'h0005, 16'h0005, 16'h0005, 16'h0005, 1'b0);
    chk("addi_res_valid", 66'(res_valid), 66'd1);
    chk("addi_res_data", 66'(res_data), 66'h0005_0005_0005_0005);
    chk("addi_res_fail", 66'(res_fail), 66'd0);
    chk("addi_res_timeout", 66'(res_timeout), 66'd0);
    chk("addi_issued", 66'(issued_cnt), 66'd1);
    chk("addi_fail_cnt", 66'(fail_cnt), 66'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("addi_res_drop", 66'(res_valid), 66'd0);
    chk("addi_idle_busy", 66'(busy), 66'd0);
    chk("addi_iv_pulses", 66'(iv_cnt - iv0), 66'd1);

    // back-to-back, res_ready tied high
    do_reset();
    res_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          cmd_valid = 1'b1;
          cmd_instruction = 32'h2000_0000 + 32'(k);
          cmd_output_reg = 20'(k);
          tick();
        end
        cmd_valid = 1'b0;
        chk("b2b_cmd_ready_after_pop", 66'(cmd_ready), 66'd1);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          wait_iv(ci[k]);
          chk("b2b_instr_order", 66'(core_if.instruction), 66'(32'h2000_0000 + 32'(k)));
          chk("b2b_oreg_order", 66'(core_if.output_reg), 66'(k));
          tick();
          tick();
          core_resp(16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'h0300 + 16'(k), 16'h0400 + 16'(k), 1'b0);
        end
      end
    join
    tick();
    tick();
    chk("b2b_result_count", 66'(rq.size()), 66'd4);
    for (int k = 0; k < 4; k++) chk("b2b_result", rq[k], {2'b00, mk(k)});
    for (int k = 0; k < 3; k++) chk("b2b_issue_period", 66'(ci[k+1] - ci[k]), 66'd5);
    chk("b2b_issued", 66'(issued_cnt), 66'd4);
    chk("b2b_fail_cnt", 66'(fail_cnt), 66'd0);
    res_ready = 1'b0;

    // fail path
    do_reset();
    cmd_valid = 1'b1;
    cmd_instruction = 32'hFFFF_FFFF;
    cmd_output_reg = 20'h00001;
    tick();
    cmd_valid = 1'b0;
    wait_iv(c0);
    tick();
    tick();
    core_resp(16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("fail_res_valid", 66'(res_valid), 66'd1);
    chk("fail_res_fail", 66'(res_fail), 66'd1);
    chk("fail_res_data", 66'(res_data), 66'd0);
    chk("fail_res_timeout", 66'(res_timeout), 66'd0);
    chk("fail_cnt", 66'(fail_cnt), 66'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // timeout, then a late response that must be ignored
    do_reset();
    cmd_valid = 1'b1;
    cmd_instruction = 32'h1234_5678;
    cmd_output_reg = 20'h00002;
    tick();
    cmd_valid = 1'b0;
    wait_iv(c0);
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    chk("to_latency", 66'(cyc - c0), 66'd64);
    chk("to_res_timeout", 66'(res_timeout), 66'd1);
    chk("to_res_data", 66'(res_data), 66'd0);
    chk("to_res_fail", 66'(res_fail), 66'd0);
    chk("to_fail_cnt", 66'(fail_cnt), 66'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    qs = rq.size();
    for (int i = 0; i < 9; i++) tick();
    core_resp(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    tick();
    tick();
    chk("late_res_valid", 66'(res_valid), 66'd0);
    chk("late_no_result", 66'(rq.size()), 66'(qs));
    chk("late_fail_cnt", 66'(fail_cnt), 66'd1);
    chk("late_busy", 66'(busy), 66'd0);

    // backpressure with queued commands, then reset in WAIT
    do_reset();
    cmd_valid = 1'b1;
    cmd_instruction = 32'h3000_000A;
    cmd_output_reg = 20'h0000A;
    tick();
    cmd_instruction = 32'h3000_000B;
    cmd_output_reg = 20'h0000B;
    tick();
    cmd_valid = 1'b0;
    wait_iv(c0);
    chk("bp_first_instr", 66'(core_if.instruction), 66'h3000_000A);
    tick();
    tick();
    core_resp(16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 1'b0);
    chk("bp_res_valid", 66'(res_valid), 66'd1);
    iv0 = iv_cnt;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== 64'h00A4_00A3_00A2_00A1) stable = 1'b0;
    end
    chk("bp_stable", 66'(stable), 66'd1);
    chk("bp_no_issue", 66'(iv_cnt - iv0), 66'd0);
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1;
      cmd_instruction = 32'h3000_000C + 32'(k);
      cmd_output_reg = 20'h0000C + 20'(k);
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_full_cmd_ready", 66'(cmd_ready), 66'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release_drop", 66'(res_valid), 66'd0);
    tick();
    chk("bp_second_iv", 66'(core_if.in_valid), 66'd1);
    chk("bp_second_instr", 66'(core_if.instruction), 66'h3000_000B);
    chk("bp_issued", 66'(issued_cnt), 66'd1);
    tick();

    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    iv0 = iv_cnt;
    chk("rw_cmd_ready", 66'(cmd_ready), 66'd1);
    chk("rw_in_valid", 66'(core_if.in_valid), 66'd0);
    chk("rw_res_valid", 66'(res_valid), 66'd0);
    chk("rw_busy", 66'(busy), 66'd0);
    chk("rw_issued", 66'(issued_cnt), 66'd0);
    core_resp(16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4, 1'b1);
    tick();
    tick();
    chk("rw_ignored_res_valid", 66'(res_valid), 66'd0);
    chk("rw_ignored_res_data", 66'(res_data), 66'd0);
    chk("rw_fail_cnt", 66'(fail_cnt), 66'd0);
    chk("rw_issued_after", 66'(issued_cnt), 66'd0);
    chk("rw_no_issue", 66'(iv_cnt - iv0), 66'd0);
    chk("rw_fifo_empty", 66'(busy), 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_host_driver.md
Name: mips_host_driver

Overview:
- Host-side initiator for the MIPS core's single-instruction interface.
- Buffers instruction/output-register commands from a producer in a small FIFO and issues them one at a time with a one-cycle in_valid pulse.
- Captures the core's one-cycle out_valid response (out_1..out_4, instruction_fail) and presents it on a valid/ready result port.
- Includes a timeout watchdog and status counters. Sits between the testbench/host sequencer and the MIPS core.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2).
- TIMEOUT, 64, max cycles from in_valid to out_valid before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset. One clock; reset is synchronous and active-high.
- cmd_valid  in  1  producer command valid
- cmd_ready  out  1  FIFO not full
- cmd_instruction  in  32  instruction to issue
- cmd_output_reg  in  20  four 5-bit output register addresses
- in_valid  out  1  issue pulse to core
- instruction  out  32  to core
- output_reg  out  20  to core
- out_valid  in  1  core response valid (1 cycle)
- out_1, out_2, out_3, out_4  in  16 each  core results
- instruction_fail  in  1  core fail flag
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  64  {out_4,out_3,out_2,out_1}
- res_fail  out  1  captured instruction_fail
- res_timeout  out  1  result produced by watchdog
- busy  out  1  FSM not IDLE or FIFO not empty
- issued_cnt  out  8  instructions issued
- fail_cnt  out  8  fails plus timeouts

Behaviour:
- Reset (rst_n=1 at posedge):
  - FIFO empties, FSM goes to IDLE.
  - All outputs are 0 except cmd_ready=1.
  - Reset overrides any concurrent event.
  - A core out_valid that arrives after reset while in IDLE is ignored.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = !full, registered state only; a same-cycle pop does not raise cmd_ready.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
  - Push and pop in the same cycle with 0 < count < DEPTH: count unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty and !res_valid, pop head, go to ISSUE.
  - ISSUE: in_valid=1 for exactly this cycle; instruction/output_reg = popped entry. Otherwise both are 0. issued_cnt += 1 (wraps 255->0). Clear the watchdog. Go to WAIT.
  - WAIT: watchdog increments each cycle.
    - On out_valid: register res_data, res_fail=instruction_fail, res_timeout=0, then go to RESP.
    - If watchdog reaches TIMEOUT without out_valid: res_data=0, res_fail=0, res_timeout=1, then go to RESP.
    - out_valid in the same cycle the watchdog reaches TIMEOUT: the response wins.
  - RESP: res_valid=1; result fields are stable until the handshake.
    - On res_ready: res_valid drops next cycle, go to IDLE.
    - fail_cnt += 1 on entry to RESP if res_fail or res_timeout (saturates at 255).
- Issue spacing:
  - Next in_valid is at least 2 cycles after the accepted out_valid (RESP + IDLE), which satisfies the core's return to idle.
  - Minimum issue-to-issue period with res_ready tied high: in_valid (ISSUE), core ≥2 cycles, RESP, IDLE, ISSUE.
  - in_valid is never asserted while the core response is outstanding.
- out_valid outside WAIT (late response after timeout, spurious pulse): ignored, no state or counter change.
- busy = (state != IDLE) || count != 0.

Test Plan:
- Single ADDI: push instruction=32'h2232_0005, output_reg=20'h94A52; core model responds out_1..4=16'h0005 two cycles after in_valid → exactly one in_valid pulse, res_valid with res_data=64'h0005_0005_0005_0005, res_fail=0, issued_cnt=1, fail_cnt=0.
- Back-to-back: push 4 commands with res_ready=1 → cmd_ready=0 after the 4th push only if none has popped yet. The four in_valid pulses are each separated by ≥2 cycles after the previous out_valid, results return in push order, issued_cnt=4.
- Fail path: core returns instruction_fail=1, out_1..4=0 → res_fail=1, res_data=0, fail_cnt=1.
- Timeout: core never responds → res_timeout=1 exactly TIMEOUT (64) cycles after in_valid, fail_cnt=1. A late out_valid 10 cycles later is ignored, with no second result.
- Backpressure: hold res_ready=0 for 20 cycles with 2 queued commands → res_valid stays high with stable data, no new in_valid. Release → the second command issues.
- Reset mid-WAIT: assert rst_n one cycle during WAIT → all outputs are 0 and cmd_ready=1 the next cycle, FIFO empty. The following out_valid is ignored and counters stay 0.
